// File: rtl/product_accumulator_pkg.sv
// Shared types and constants for the product accumulator and its adder.
package product_accumulator_pkg;

  // Block state: accumulating products, or holding a finished block result.
  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  // Overflow policy selectors for the SAT parameter.
  localparam bit SAT_ON  = 1'b1;
  localparam bit SAT_OFF = 1'b0;

  // Default geometry.
  localparam int ACC_W_DEF = 24;
  localparam int LEN_DEF   = 8;

  // Product width delivered by the 8x8 array multiplier.
  localparam int PROD_W = 16;

endpackage : product_accumulator_pkg

// File: rtl/product_accumulator_sat_add.sv
// Combinational ACC_W-bit + PROD_W-bit unsigned adder with carry-out and an
// optional clamp to all-ones when the sum does not fit in ACC_W bits.
module sat_add
  import product_accumulator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter bit SAT   = SAT_ON
) (
  input  logic [ACC_W-1:0]  a_i,
  input  logic [PROD_W-1:0] b_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              carry_o
);

  logic [ACC_W:0] sum_full_s;

  // Add at ACC_W+1 bits so the carry-out is the overflow flag.
  always_comb begin
    sum_full_s = {1'b0, a_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, b_i};
    carry_o    = sum_full_s[ACC_W];
    if (carry_o && SAT) begin
      sum_o = {ACC_W{1'b1}};
    end else begin
      sum_o = sum_full_s[ACC_W-1:0];
    end
  end

endmodule : sat_add

// File: rtl/product_accumulator.sv
// Block accumulator for the multiplier product stream: sums up to LEN
// products (or fewer, ended by IN_LAST) and offers the block sum, count and
// sticky overflow flag through a valid/ready handshake.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int    ACC_W = ACC_W_DEF,
  parameter int    LEN   = LEN_DEF,
  parameter bit    SAT   = SAT_ON,
  localparam int   CNT_W = $clog2(LEN + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [PROD_W-1:0] P_IN,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic              IN_LAST,
  output logic [ACC_W-1:0]  ACC_OUT,
  output logic [CNT_W-1:0]  CNT_OUT,
  output logic              OVF,
  output logic              OUT_VALID,
  input  logic              OUT_READY
);

  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] sum_s;
  logic             carry_s;
  logic [CNT_W-1:0] cnt_inc_s;

  sat_add #(
    .ACC_W (ACC_W),
    .SAT   (SAT)
  ) u_sat_add (
    .a_i     (acc_q),
    .b_i     (P_IN),
    .sum_o   (sum_s),
    .carry_o (carry_s)
  );

  assign cnt_inc_s = cnt_q + CNT_W'(1);

  // Next-state logic: accept products in ACC, wait for the consumer in DONE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_ACC: begin
        if (IN_VALID) begin
          acc_d = sum_s;
          cnt_d = cnt_inc_s;
          ovf_d = ovf_q | carry_s;
          if (IN_LAST || (cnt_inc_s == LEN_C)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACC;
          end
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_DONE: begin
        if (OUT_READY) begin
          state_d = ST_ACC;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_ACC;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  // State and result registers; reset discards any pending block.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Ready depends only on state and reset, never on IN_VALID.
  assign IN_READY  = (state_q == ST_ACC) && !RST;
  assign OUT_VALID = (state_q == ST_DONE);
  assign ACC_OUT   = acc_q;
  assign CNT_OUT   = cnt_q;
  assign OVF       = ovf_q;

endmodule : product_accumulator

// File: tb/tb_product_accumulator.sv
// Self-checking bench: three accumulators (24-bit saturating, 17-bit
// saturating, 17-bit wrapping, all LEN=8) share one input stream and are
// compared against an arithmetic block-sum model.
module tb_product_accumulator;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] P_IN;
  logic        IN_VALID;
  logic        IN_LAST;
  logic        OUT_READY;

  logic        ir_o  [3];
  logic        ov_o  [3];
  logic        ovf_o [3];
  logic [3:0]  cnt_o [3];
  logic [31:0] acc_o [3];

  logic [23:0] acc0_w;
  logic [16:0] acc1_w, acc2_w;

  int chk_total = 0;
  int chk_pass  = 0;

  // Model configuration and state, one entry per instance.
  int    aw_t  [3] = '{24, 17, 17};
  bit    sat_t [3] = '{1'b1, 1'b1, 1'b0};
  longint m_acc [3];
  bit    m_ovf [3];
  int    m_cnt;

  always #5 CLK = ~CLK;

  product_accumulator #(.ACC_W(24), .LEN(8), .SAT(1'b1)) u_dut0 (
    .CLK(CLK), .RST(RST), .P_IN(P_IN), .IN_VALID(IN_VALID), .IN_READY(ir_o[0]),
    .IN_LAST(IN_LAST), .ACC_OUT(acc0_w), .CNT_OUT(cnt_o[0]), .OVF(ovf_o[0]),
    .OUT_VALID(ov_o[0]), .OUT_READY(OUT_READY));

  product_accumulator #(.ACC_W(17), .LEN(8), .SAT(1'b1)) u_dut1 (
    .CLK(CLK), .RST(RST), .P_IN(P_IN), .IN_VALID(IN_VALID), .IN_READY(ir_o[1]),
    .IN_LAST(IN_LAST), .ACC_OUT(acc1_w), .CNT_OUT(cnt_o[1]), .OVF(ovf_o[1]),
    .OUT_VALID(ov_o[1]), .OUT_READY(OUT_READY));

  product_accumulator #(.ACC_W(17), .LEN(8), .SAT(1'b0)) u_dut2 (
    .CLK(CLK), .RST(RST), .P_IN(P_IN), .IN_VALID(IN_VALID), .IN_READY(ir_o[2]),
    .IN_LAST(IN_LAST), .ACC_OUT(acc2_w), .CNT_OUT(cnt_o[2]), .OVF(ovf_o[2]),
    .OUT_VALID(ov_o[2]), .OUT_READY(OUT_READY));

  // Widen the differently sized sums into one array for uniform checking.
  always_comb begin
    acc_o[0] = {8'd0, acc0_w};
    acc_o[1] = {15'd0, acc1_w};
    acc_o[2] = {15'd0, acc2_w};
  end

  function automatic void model_clear();
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 0;
      m_ovf[k] = 1'b0;
    end
    m_cnt = 0;
  endfunction

  // One accepted product: add, then clamp or wrap if the sum no longer fits.
  function automatic void model_add(input int unsigned p);
    longint maxv;
    for (int k = 0; k < 3; k++) begin
      maxv = (longint'(1) << aw_t[k]) - 1;
      m_acc[k] = m_acc[k] + p;
      if (m_acc[k] > maxv) begin
        m_ovf[k] = 1'b1;
        m_acc[k] = sat_t[k] ? maxv : (m_acc[k] - (maxv + 1));
      end
    end
    m_cnt++;
  endfunction

  // {OUT_VALID, IN_READY, ACC_OUT, CNT_OUT, OVF}
  function automatic logic [38:0] obs_vec(input int k);
    return {ov_o[k], ir_o[k], acc_o[k], cnt_o[k], ovf_o[k]};
  endfunction

  function automatic logic [38:0] exp_vec(input int k, input bit done, input bit rdy);
    logic [31:0] a;
    logic [3:0]  c;
    a = m_acc[k][31:0];
    c = m_cnt[3:0];
    return {done, rdy, a, c, m_ovf[k]};
  endfunction

  task automatic release_result();
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    model_clear();
  endtask

  task automatic send_block(input int unsigned prods[$], input bit use_last, input int gapmax);
    for (int i = 0; i < prods.size(); i++) begin
      repeat ($urandom_range(gapmax, 0)) begin
        IN_VALID = 1'b0;
        P_IN     = 16'($urandom);
        @(posedge CLK); #1;
      end
      IN_VALID = 1'b1;
      P_IN     = prods[i][15:0];
      IN_LAST  = use_last && (i == prods.size() - 1);
      @(posedge CLK);
      model_add(prods[i]);
      #1;
    end
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; IN_VALID = 1'b0; IN_LAST = 1'b0; OUT_READY = 1'b0; P_IN = 16'd0;
    model_clear();
    repeat (2) @(posedge CLK);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk_total++;
      if (obs_vec(k) !== exp_vec(k, 1'b0, 1'b0))
        $display("FAIL reset_hold[%0d] got %h want %h", k, obs_vec(k), exp_vec(k, 1'b0, 1'b0));
      else chk_pass++;
    end
    RST = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk_total++;
      if (obs_vec(k) !== exp_vec(k, 1'b0, 1'b1))
        $display("FAIL reset_release[%0d] got %h want %h", k, obs_vec(k), exp_vec(k, 1'b0, 1'b1));
      else chk_pass++;
    end
  endtask

  task automatic test_full_block();
    int unsigned q[$];
    for (int i = 0; i < 8; i++) q.push_back(32'd38000);
    send_block(q, 1'b0, 0);
    chk_total++;
    if (acc_o[0] !== 32'd304000 || cnt_o[0] !== 4'd8 || ov_o[0] !== 1'b1 || ir_o[0] !== 1'b0)
      $display("FAIL full_block_const got acc=%0d cnt=%0d ov=%b ir=%b want acc=304000 cnt=8 ov=1 ir=0",
               acc_o[0], cnt_o[0], ov_o[0], ir_o[0]);
    else chk_pass++;
    for (int k = 0; k < 3; k++) begin
      chk_total++;
      if (obs_vec(k) !== exp_vec(k, 1'b1, 1'b0))
        $display("FAIL full_block[%0d] got %h want %h", k, obs_vec(k), exp_vec(k, 1'b1, 1'b0));
      else chk_pass++;
    end
    release_result();
  endtask

  task automatic test_early_last();
    int unsigned q[$];
    q = '{32'd12816, 32'd1000, 32'd65025};
    send_block(q, 1'b1, 0);
    chk_total++;
    if (acc_o[0] !== 32'd78841 || cnt_o[0] !== 4'd3 || ov_o[0] !== 1'b1)
      $display("FAIL early_last_const got acc=%0d cnt=%0d ov=%b want acc=78841 cnt=3 ov=1",
               acc_o[0], cnt_o[0], ov_o[0]);
    else chk_pass++;
    for (int k = 0; k < 3; k++) begin
      chk_total++;
      if (obs_vec(k) !== exp_vec(k, 1'b1, 1'b0))
        $display("FAIL early_last[%0d] got %h want %h", k, obs_vec(k), exp_vec(k, 1'b1, 1'b0));
      else chk_pass++;
    end
  endtask

  // Runs while the early-termination result is still pending.
  task automatic test_backpressure();
    for (int c = 0; c < 5; c++) begin
      IN_VALID = 1'b1;
      IN_LAST  = 1'($urandom);
      P_IN     = 16'($urandom);
      @(posedge CLK); #1;
      for (int k = 0; k < 3; k++) begin
        chk_total++;
        if (obs_vec(k) !== exp_vec(k, 1'b1, 1'b0))
          $display("FAIL backpressure_hold[%0d] cyc %0d got %h want %h", k, c, obs_vec(k), exp_vec(k, 1'b1, 1'b0));
        else chk_pass++;
      end
    end
    release_result();
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_total++;
      if (obs_vec(k) !== exp_vec(k, 1'b0, 1'b1))
        $display("FAIL backpressure_release[%0d] got %h want %h", k, obs_vec(k), exp_vec(k, 1'b0, 1'b1));
      else chk_pass++;
    end
  endtask

  task automatic test_overflow();
    int unsigned q[$];
    q = '{32'd65025, 32'd65025, 32'd65025};
    send_block(q, 1'b1, 0);
    chk_total++;
    if (acc_o[1] !== 32'd131071 || ovf_o[1] !== 1'b1 || acc_o[2] !== 32'd64003 || ovf_o[2] !== 1'b1)
      $display("FAIL overflow_const got sat=%0d/%b wrap=%0d/%b want sat=131071/1 wrap=64003/1",
               acc_o[1], ovf_o[1], acc_o[2], ovf_o[2]);
    else chk_pass++;
    for (int k = 0; k < 3; k++) begin
      chk_total++;
      if (obs_vec(k) !== exp_vec(k, 1'b1, 1'b0))
        $display("FAIL overflow[%0d] got %h want %h", k, obs_vec(k), exp_vec(k, 1'b1, 1'b0));
      else chk_pass++;
    end
    release_result();
    q = '{32'd1000, 32'd2000};
    send_block(q, 1'b1, 0);
    for (int k = 0; k < 3; k++) begin
      chk_total++;
      if (ovf_o[k] !== 1'b0 || obs_vec(k) !== exp_vec(k, 1'b1, 1'b0))
        $display("FAIL overflow_next_block[%0d] got %h want %h", k, obs_vec(k), exp_vec(k, 1'b1, 1'b0));
      else chk_pass++;
    end
    release_result();
  endtask

  task automatic test_reset_mid();
    int unsigned q[$];
    for (int i = 0; i < 4; i++) q.push_back($urandom_range(65535, 0));
    send_block(q, 1'b0, 1);
    RST = 1'b1;
    #1;
    chk_total++;
    if (ir_o[0] !== 1'b0)
      $display("FAIL reset_mid_ready got %b want 0", ir_o[0]);
    else chk_pass++;
    @(posedge CLK); #1;
    RST = 1'b0;
    model_clear();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk_total++;
      if (obs_vec(k) !== exp_vec(k, 1'b0, 1'b1))
        $display("FAIL reset_mid[%0d] got %h want %h", k, obs_vec(k), exp_vec(k, 1'b0, 1'b1));
      else chk_pass++;
    end
    // Reset while a result is pending discards it.
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back($urandom_range(65535, 0));
    send_block(q, 1'b0, 0);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    model_clear();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk_total++;
      if (obs_vec(k) !== exp_vec(k, 1'b0, 1'b1))
        $display("FAIL reset_done[%0d] got %h want %h", k, obs_vec(k), exp_vec(k, 1'b0, 1'b1));
      else chk_pass++;
    end
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(32'd1000);
    send_block(q, 1'b0, 0);
    chk_total++;
    if (acc_o[0] !== 32'd8000 || cnt_o[0] !== 4'd8 || ov_o[0] !== 1'b1)
      $display("FAIL reset_after_block got acc=%0d cnt=%0d ov=%b want acc=8000 cnt=8 ov=1",
               acc_o[0], cnt_o[0], ov_o[0]);
    else chk_pass++;
    release_result();
  endtask

  task automatic test_gapped();
    int n;
    n = 0;
    while (n < 8) begin
      repeat ($urandom_range(3, 0)) begin
        IN_VALID = 1'b0;
        IN_LAST  = 1'($urandom);
        P_IN     = 16'($urandom);
        @(posedge CLK); #1;
        chk_total++;
        if (obs_vec(0) !== exp_vec(0, 1'b0, 1'b1))
          $display("FAIL gapped_bubble got %h want %h", obs_vec(0), exp_vec(0, 1'b0, 1'b1));
        else chk_pass++;
      end
      IN_VALID = 1'b1;
      IN_LAST  = 1'b0;
      P_IN     = 16'd38000;
      @(posedge CLK);
      model_add(32'd38000);
      n++;
      #1;
    end
    IN_VALID = 1'b0;
    chk_total++;
    if (acc_o[0] !== 32'd304000 || cnt_o[0] !== 4'd8 || ov_o[0] !== 1'b1)
      $display("FAIL gapped_final got acc=%0d cnt=%0d ov=%b want acc=304000 cnt=8 ov=1",
               acc_o[0], cnt_o[0], ov_o[0]);
    else chk_pass++;
    for (int k = 1; k < 3; k++) begin
      chk_total++;
      if (obs_vec(k) !== exp_vec(k, 1'b1, 1'b0))
        $display("FAIL gapped[%0d] got %h want %h", k, obs_vec(k), exp_vec(k, 1'b1, 1'b0));
      else chk_pass++;
    end
    release_result();
  endtask

  task automatic test_back_to_back_random();
    int unsigned q[$];
    int len;
    bit lst;
    for (int b = 0; b < 12; b++) begin
      q.delete();
      len = $urandom_range(8, 1);
      lst = (len < 8) ? 1'b1 : 1'($urandom);
      for (int i = 0; i < len; i++) q.push_back($urandom_range(65535, 0));
      send_block(q, lst, $urandom_range(2, 0));
      for (int k = 0; k < 3; k++) begin
        chk_total++;
        if (obs_vec(k) !== exp_vec(k, 1'b1, 1'b0))
          $display("FAIL random_block%0d[%0d] got %h want %h", b, k, obs_vec(k), exp_vec(k, 1'b1, 1'b0));
        else chk_pass++;
      end
      repeat ($urandom_range(2, 0)) begin
        @(posedge CLK); #1;
      end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_early_last();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_gapped();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule : tb_product_accumulator

// File: doc/product_accumulator.md
# product_accumulator

Sequential stage directly downstream of the 8-bit array multiplier: it consumes the 16-bit product stream, sums a block of `LEN` products (or fewer if `IN_LAST` is seen) into a wider accumulator, and presents the block sum with a valid/ready handshake. It turns the purely combinational multiplier into a usable dot-product / MAC datapath.

## Interface
- `ACC_W`, 24: accumulator and result width; legal range 17..32.
- `LEN`, 8: products per block; legal range 1..256.
- `SAT`, 1: 1 = saturate at 2^ACC_W−1; 0 = wrap modulo 2^ACC_W.
- `CLK` in 1: the single clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `P_IN` in 16: unsigned product from the multiplier.
- `IN_VALID` in 1: `P_IN` is valid this cycle.
- `IN_READY` out 1: block can accept `P_IN`.
- `IN_LAST` in 1: the accepted product is the last one of the block; sampled only on accept.
- `ACC_OUT` out `ACC_W`: registered running/final sum.
- `CNT_OUT` out `$clog2(LEN+1)`: number of products accumulated in the current block.
- `OVF` out 1: sticky per block; set if any addition exceeded 2^ACC_W−1.
- `OUT_VALID` out 1: `ACC_OUT`/`CNT_OUT`/`OVF` hold a completed block result.
- `OUT_READY` in 1: consumer takes the result.

## Operation
- Two states:
  - **ACC**: `IN_READY`=1, `OUT_VALID`=0.
  - **DONE**: `IN_READY`=0, `OUT_VALID`=1.
- **Accept**: `IN_VALID & IN_READY` at a rising edge. On accept:
  - `acc <= acc + P_IN`, unsigned, computed at `ACC_W+1` bits.
  - If the carry-out is set: `OVF <= 1`; result is 2^ACC_W−1 when `SAT`=1, or the low `ACC_W` bits when `SAT`=0.
  - `cnt <= cnt+1`.
- **ACC → DONE**: on the accept that makes `cnt == LEN`, or on any accept with `IN_LAST`=1. The final sum, count and `OVF` are registered on that same edge.
- **DONE → ACC**: on an edge with `OUT_READY`=1. `acc`, `cnt` and `OVF` clear to 0 on that edge.
- **Idle inputs**:
  - `IN_VALID` is ignored in DONE.
  - `OUT_READY` is ignored in ACC.
  - `IN_LAST` is ignored without an accept.
- `IN_READY` is a function of state and `RST` only; it never depends on `IN_VALID`.
- In ACC, `ACC_OUT` and `CNT_OUT` show running values. They are meaningful to the consumer only while `OUT_VALID`=1.
- With `LEN`=1, every accept completes a block.

## Timing
- **Reset**: while `RST`=1, `IN_READY`=0. After the reset edge, state is ACC and `ACC_OUT`=0, `CNT_OUT`=0, `OVF`=0, `OUT_VALID`=0. `IN_READY`=1 from the first cycle `RST` is low.
- **Reset priority**: `RST` dominates everything, mid-block or in DONE. A pending result is discarded.
- **Latency**:
  - A product accepted at edge k is reflected in `ACC_OUT` after edge k.
  - `OUT_VALID` rises after the final accept edge, with zero added cycles.
- **Throughput**: one product per cycle within a block. There is one mandatory bubble per block (the DONE cycle), so minimum period is `LEN`+1 cycles.
- **Backpressure**: while `OUT_VALID`=1 and `OUT_READY`=0, all outputs hold stable for an unbounded time.
- **Input gaps**: bubbles on `IN_VALID` do not change the sum or the count.

## Structure
- **Shared package**:
  - State enum (`ST_ACC`, `ST_DONE`).
  - `SAT_ON`/`SAT_OFF` constants.
  - Default `ACC_W`/`LEN` localparams.
  - `PROD_W` = 16, shared with the multiplier.
- **Sub-module** `sat_add`: parameterised `ACC_W`-bit plus 16-bit unsigned adder with carry-out and `SAT` select. Purely combinational.
- **Top level**: state register, counter, result registers.

## Test plan
- **Full block**: `LEN`=8, `ACC_W`=24, `P_IN`=38000 (200×190) on 8 back-to-back accepts → `OUT_VALID`=1 after the 8th edge with `ACC_OUT`=304000, `CNT_OUT`=8, `OVF`=0; `IN_READY`=0 in that cycle.
- **Early termination**: `P_IN`=12816, 1000, 65025 with `IN_LAST` on the third accept → `ACC_OUT`=78841, `CNT_OUT`=3.
- **Backpressure**:
  - Hold `OUT_READY`=0 for 5 cycles with `IN_VALID`=1 → outputs unchanged and no input consumed.
  - Then `OUT_READY`=1 → next cycle `OUT_VALID`=0, `ACC_OUT`=0, `IN_READY`=1.
- **Overflow**: `ACC_W`=17, 3×65025 with `IN_LAST` on the third accept.
  - `SAT`=1 → `ACC_OUT`=131071, `OVF`=1.
  - `SAT`=0 → `ACC_OUT`=64003, `OVF`=1.
  - `OVF`=0 in the next block.
- **Reset mid-block**: `RST` pulsed after 4 accepts → next cycle `ACC_OUT`=0, `CNT_OUT`=0. A following 8×1000 block gives 8000.
- **Gapped input**: 8×38000 with random `IN_VALID` bubbles (0–3 cycles) → `ACC_OUT`=304000, `CNT_OUT`=8, identical to the full-block case.
